// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters with sync/blank generation and a pixel-tick-aligned delay pipeline
`timescale 1ns/1ps

module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int PIPE_DLY  = 1
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        pix_en,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs_out,
  output logic        vs_out,
  output logic        blank_out,
  output logic        sync,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0]  drawx_q, drawx_d;
  logic [9:0]  drawy_q, drawy_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        x_wrap, y_wrap;
  logic        hs_raw, vs_raw, blank_raw;

  assign x_wrap = (drawx_q == H_LAST);
  assign y_wrap = (drawy_q == V_LAST);

  always_comb begin
    drawx_d     = drawx_q;
    drawy_d     = drawy_q;
    frame_cnt_d = frame_cnt_q;
    if (pix_en) begin
      if (x_wrap) begin
        drawx_d = '0;
        if (y_wrap) begin
          drawy_d     = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          drawy_d = drawy_q + 10'd1;
        end
      end else begin
        drawx_d = drawx_q + 10'd1;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      drawx_q     <= '0;
      drawy_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      drawx_q     <= drawx_d;
      drawy_q     <= drawy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Syncs are active low inside their pulse windows; blank is high during active video.
  assign blank_raw = (drawx_q < 10'(H_VISIBLE)) && (drawy_q < 10'(V_VISIBLE));
  assign hs_raw    = !((drawx_q >= H_SYNC_START) && (drawx_q < H_SYNC_END));
  assign vs_raw    = !((drawy_q >= V_SYNC_START) && (drawy_q < V_SYNC_END));

  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign hs_out    = hs_raw;
      assign vs_out    = vs_raw;
      assign blank_out = blank_raw;
    end else begin : g_dly
      logic [PIPE_DLY-1:0] hs_pipe_q, hs_pipe_d;
      logic [PIPE_DLY-1:0] vs_pipe_q, vs_pipe_d;
      logic [PIPE_DLY-1:0] bl_pipe_q, bl_pipe_d;

      always_comb begin
        hs_pipe_d = hs_pipe_q;
        vs_pipe_d = vs_pipe_q;
        bl_pipe_d = bl_pipe_q;
        if (pix_en) begin
          hs_pipe_d[0] = hs_raw;
          vs_pipe_d[0] = vs_raw;
          bl_pipe_d[0] = blank_raw;
          for (int i = 1; i < PIPE_DLY; i++) begin
            hs_pipe_d[i] = hs_pipe_q[i-1];
            vs_pipe_d[i] = vs_pipe_q[i-1];
            bl_pipe_d[i] = bl_pipe_q[i-1];
          end
        end
      end

      // Every stage resets to the idle (non-sync, blanked) level.
      always_ff @(posedge vga_clk) begin
        if (reset) begin
          hs_pipe_q <= '1;
          vs_pipe_q <= '1;
          bl_pipe_q <= '0;
        end else begin
          hs_pipe_q <= hs_pipe_d;
          vs_pipe_q <= vs_pipe_d;
          bl_pipe_q <= bl_pipe_d;
        end
      end

      assign hs_out    = hs_pipe_q[PIPE_DLY-1];
      assign vs_out    = vs_pipe_q[PIPE_DLY-1];
      assign blank_out = bl_pipe_q[PIPE_DLY-1];
    end
  endgenerate

  assign DrawX       = drawx_q;
  assign DrawY       = drawy_q;
  assign blank       = blank_raw;
  assign sync        = 1'b0;
  assign line_start  = pix_en && (drawx_q == 10'd0);
  assign frame_start = pix_en && (drawx_q == 10'd0) && (drawy_q == 10'd0);
  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed checks of vga_timing_gen at default, small and 1x1 raster sizes
`timescale 1ns/1ps

module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic en;

  always #5 clk = ~clk;

  logic [9:0]  d_x, d_y, s0_x, s0_y, s3_x, s3_y, o_x, o_y;
  logic        d_blank, d_hs, d_vs, d_bo, d_sync, d_ls, d_fs;
  logic        s0_blank, s0_hs, s0_vs, s0_bo, s0_sync, s0_ls, s0_fs;
  logic        s3_blank, s3_hs, s3_vs, s3_bo, s3_sync, s3_ls, s3_fs;
  logic        o_blank, o_hs, o_vs, o_bo, o_sync, o_ls, o_fs;
  logic [15:0] d_fc, s0_fc, s3_fc, o_fc;

  vga_timing_gen #(.PIPE_DLY(1)) u_def (
    .vga_clk(clk), .reset(rst), .pix_en(en), .DrawX(d_x), .DrawY(d_y), .blank(d_blank),
    .hs_out(d_hs), .vs_out(d_vs), .blank_out(d_bo), .sync(d_sync), .line_start(d_ls),
    .frame_start(d_fs), .frame_count(d_fc));

  vga_timing_gen #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_VISIBLE(4), .V_FP(1),
                   .V_SYNC(2), .V_BP(1), .PIPE_DLY(0)) u_s0 (
    .vga_clk(clk), .reset(rst), .pix_en(en), .DrawX(s0_x), .DrawY(s0_y), .blank(s0_blank),
    .hs_out(s0_hs), .vs_out(s0_vs), .blank_out(s0_bo), .sync(s0_sync), .line_start(s0_ls),
    .frame_start(s0_fs), .frame_count(s0_fc));

  vga_timing_gen #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_VISIBLE(4), .V_FP(1),
                   .V_SYNC(2), .V_BP(1), .PIPE_DLY(3)) u_s3 (
    .vga_clk(clk), .reset(rst), .pix_en(en), .DrawX(s3_x), .DrawY(s3_y), .blank(s3_blank),
    .hs_out(s3_hs), .vs_out(s3_vs), .blank_out(s3_bo), .sync(s3_sync), .line_start(s3_ls),
    .frame_start(s3_fs), .frame_count(s3_fc));

  vga_timing_gen #(.H_VISIBLE(1), .H_FP(0), .H_SYNC(0), .H_BP(0), .V_VISIBLE(1), .V_FP(0),
                   .V_SYNC(0), .V_BP(0), .PIPE_DLY(0)) u_one (
    .vga_clk(clk), .reset(rst), .pix_en(en), .DrawX(o_x), .DrawY(o_y), .blank(o_blank),
    .hs_out(o_hs), .vs_out(o_vs), .blank_out(o_bo), .sync(o_sync), .line_start(o_ls),
    .frame_start(o_fs), .frame_count(o_fc));

  int n_pass;
  int n_total;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic f_blank(input int x, input int y, input int hv, input int vv);
    return (x < hv) && (y < vv);
  endfunction

  function automatic logic f_sync(input int c, input int vis, input int fp, input int s);
    return !((c >= vis + fp) && (c < vis + fp + s));
  endfunction

  // Reference raster state, advanced independently of the DUT
  int dx, dy, dfc, sx, sy, sfc, ofc;
  logic dp_h, dp_v, dp_b;
  logic [2:0] h3, v3, b3;
  bit mv;

  task automatic adv(inout int x, inout int y, inout int fc, input int ht, input int vt);
    if (x == ht - 1) begin
      x = 0;
      if (y == vt - 1) begin
        y = 0;
        fc = (fc + 1) % 65536;
      end else y = y + 1;
    end else x = x + 1;
  endtask

  task automatic tick(input logic e, input logic r);
    en = e;
    rst = r;
    #2;
    if (mv) begin
      check("def_x", d_x, dx);
      check("def_y", d_y, dy);
      check("def_blank", d_blank, f_blank(dx, dy, 640, 480));
      check("def_hs_out", d_hs, dp_h);
      check("def_vs_out", d_vs, dp_v);
      check("def_blank_out", d_bo, dp_b);
      check("def_sync", d_sync, 0);
      check("def_line_start", d_ls, e && (dx == 0));
      check("def_frame_start", d_fs, e && (dx == 0) && (dy == 0));
      check("def_frame_count", d_fc, dfc);
      check("s0_x", s0_x, sx);
      check("s0_y", s0_y, sy);
      check("s0_hs_out", s0_hs, f_sync(sx, 8, 2, 3));
      check("s0_vs_out", s0_vs, f_sync(sy, 4, 1, 2));
      check("s0_blank_out", s0_bo, f_blank(sx, sy, 8, 4));
      check("s0_frame_start", s0_fs, e && (sx == 0) && (sy == 0));
      check("s0_frame_count", s0_fc, sfc);
      check("s3_x", s3_x, sx);
      check("s3_hs_out", s3_hs, h3[2]);
      check("s3_vs_out", s3_vs, v3[2]);
      check("s3_blank_out", s3_bo, b3[2]);
      check("s3_frame_count", s3_fc, sfc);
      check("one_x", o_x, 0);
      check("one_frame_start", o_fs, e);
      check("one_frame_count", o_fc, ofc);
    end
    @(posedge clk);
    #1;
    if (r) begin
      dx = 0; dy = 0; dfc = 0;
      sx = 0; sy = 0; sfc = 0; ofc = 0;
      dp_h = 1'b1; dp_v = 1'b1; dp_b = 1'b0;
      h3 = 3'b111; v3 = 3'b111; b3 = 3'b000;
      mv = 1'b1;
    end else if (e && mv) begin
      dp_h = f_sync(dx, 640, 16, 96);
      dp_v = f_sync(dy, 480, 10, 2);
      dp_b = f_blank(dx, dy, 640, 480);
      adv(dx, dy, dfc, 800, 525);
      h3 = {h3[1:0], f_sync(sx, 8, 2, 3)};
      v3 = {v3[1:0], f_sync(sy, 4, 1, 2)};
      b3 = {b3[1:0], f_blank(sx, sy, 8, 4)};
      adv(sx, sy, sfc, 16, 8);
      ofc = (ofc + 1) % 65536;
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    mv = 1'b0;
    en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    tick(0, 1);
    tick(1, 1);

    en = 1'b0;
    #1;
    check("rst_x", d_x, 0);
    check("rst_y", d_y, 0);
    check("rst_fc", d_fc, 0);
    check("rst_hs_out", d_hs, 1);
    check("rst_vs_out", d_vs, 1);
    check("rst_blank_out", d_bo, 0);
    check("rst_s3_blank_out", s3_bo, 0);
    check("rst_line_start_idle", d_ls, 0);

    en = 1'b1;
    rst = 1'b0;
    #1;
    check("first_blank", d_blank, 1);
    check("first_frame_start", d_fs, 1);
    tick(1, 0);
    check("first_x", d_x, 1);

    tick(0, 0);
    check("tog_hold_x", d_x, 1);
    tick(1, 0);
    tick(0, 0);
    check("tog_x", d_x, 2);

    repeat (900) tick(1, 0);
    check("sweep_x", d_x, 102);
    check("sweep_y", d_y, 1);
    check("sweep_s0_fc", s0_fc, 7);
    check("sweep_s0_x", s0_x, 6);
    check("sweep_one_fc", o_fc, 902);

    // Park the small raster inside both sync pulses, then reset there.
    for (int i = 0; i < 200 && !(sx == 11 && sy == 6); i++) tick(1, 0);
    en = 1'b1;
    #1;
    check("mid_s0_x", s0_x, 11);
    check("mid_s0_y", s0_y, 6);
    check("mid_s0_hs", s0_hs, 0);
    check("mid_s0_vs", s0_vs, 0);
    tick(1, 1);
    check("mid_rst_x", s3_x, 0);
    check("mid_rst_y", s3_y, 0);
    check("mid_rst_hs_out", s3_hs, 1);
    check("mid_rst_vs_out", s3_vs, 1);
    check("mid_rst_blank_out", s3_bo, 0);
    check("mid_rst_fc", s3_fc, 0);
    check("mid_rst_one_fc", o_fc, 0);

    repeat (127) tick(1, 0);
    check("frame_pre_fc", s3_fc, 0);
    check("frame_pre_x", s3_x, 15);
    check("frame_pre_y", s3_y, 7);
    tick(1, 0);
    check("frame_one_fc", s3_fc, 1);
    check("frame_one_x", s3_x, 0);
    check("frame_one_y", s3_y, 0);

    repeat (65535 - 128) tick(1, 0);
    check("one_fc_max", o_fc, 65535);
    tick(1, 0);
    check("one_fc_wrap", o_fc, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
